// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_seq
//  Purpose  : Instruction fetch sequencer. Owns the program counter, reads a
//             combinational program ROM and assembles 1- or 2-byte
//             instructions for the decoder over a valid/ready handshake.
//             Jump loads restart the fetch and discard any partial fetch.
//  Option   : FETCH_ICOUNT_EN - adds ICOUNT, a 16-bit count of completed
//             decoder handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
  parameter int                   ADDR_W    = 12,
  parameter int                   DATA_W    = 8,
  parameter int                   OPC_W     = 4,
  parameter logic [2**OPC_W-1:0]  LONG_MASK = 16'h0F00
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      LOAD,
  input  logic [ADDR_W-1:0]         LOAD_ADDR,
  output logic [ADDR_W-1:0]         MEM_ADDR,
  input  logic [DATA_W-1:0]         MEM_DATA,
  output logic                      INSTR_VALID,
  input  logic                      INSTR_READY,
  output logic [OPC_W-1:0]          OPCODE,
  output logic [DATA_W-OPC_W-1:0]   OPERAND,
  output logic [DATA_W-1:0]         IMM,
  output logic                      IS_LONG,
  output logic [ADDR_W-1:0]         INSTR_PC
`ifdef FETCH_ICOUNT_EN
  ,
  output logic [15:0]               ICOUNT
`endif
);

  localparam int OPR_W = DATA_W - OPC_W;

  typedef enum logic [1:0] {
    S_F1   = 2'd0,
    S_F2   = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                valid_q;
  logic [OPC_W-1:0]    opcode_q;
  logic [OPR_W-1:0]    operand_q;
  logic [DATA_W-1:0]   imm_q;
  logic                is_long_q;
  logic [ADDR_W-1:0]   instr_pc_q;

  logic [OPC_W-1:0]    rom_opc;
  logic [OPR_W-1:0]    rom_opr;
  logic [ADDR_W-1:0]   pc_inc;

  assign rom_opc = MEM_DATA[DATA_W-1 -: OPC_W];
  assign rom_opr = MEM_DATA[OPR_W-1:0];
  // Wraps naturally at the top of the address space.
  assign pc_inc  = pc_q + ADDR_W'(1);

  // Fetch FSM: PC, state and every decoder-facing output are registered here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_F1;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      imm_q      <= '0;
      is_long_q  <= 1'b0;
      instr_pc_q <= '0;
    end else if (EN) begin
      if (LOAD) begin
        // Jump wins over everything; a held instruction accepted in the same
        // cycle still counts as delivered, a partial one is simply dropped.
        pc_q    <= LOAD_ADDR;
        valid_q <= 1'b0;
        state_q <= S_F1;
      end else begin
        case (state_q)
          S_F1: begin
            opcode_q   <= rom_opc;
            operand_q  <= rom_opr;
            imm_q      <= '0;
            instr_pc_q <= pc_q;
            pc_q       <= pc_inc;
            if (LONG_MASK[rom_opc]) begin
              is_long_q <= 1'b1;
              state_q   <= S_F2;
            end else begin
              is_long_q <= 1'b0;
              valid_q   <= 1'b1;
              state_q   <= S_HOLD;
            end
          end
          S_F2: begin
            imm_q   <= MEM_DATA;
            pc_q    <= pc_inc;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
          S_HOLD: begin
            if (INSTR_READY) begin
              valid_q <= 1'b0;
              state_q <= S_F1;
            end
          end
          default: begin
            valid_q <= 1'b0;
            state_q <= S_F1;
          end
        endcase
      end
    end
  end

  assign MEM_ADDR    = pc_q;
  assign INSTR_VALID = valid_q;
  assign OPCODE      = opcode_q;
  assign OPERAND     = operand_q;
  assign IMM         = imm_q;
  assign IS_LONG     = is_long_q;
  assign INSTR_PC    = instr_pc_q;

`ifdef FETCH_ICOUNT_EN
  logic [15:0] icount_q;

  // Count completed handshakes, including one that coincides with a jump.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount_q <= '0;
    end else if (EN && valid_q && INSTR_READY) begin
      icount_q <= icount_q + 16'd1;
    end
  end

  assign ICOUNT = icount_q;
`endif

endmodule
`default_nettype wire
